// File: rtl/conway_seed_loader.sv
// Conway seed loader: assembles a seed frame from a byte stream into a shadow
// register, applies it to the cell grid under grid_rst, and then paces the
// grid's generation enable (free-running at a programmable period, or
// single-stepped). It also keeps the generation count for the board.
module conway_seed_loader #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic [7:0]           seed_data,
    input  logic                 seed_last,
    input  logic                 run,
    input  logic                 step,
    input  logic [PERIOD_W-1:0]  period,
    output logic [ROWS*COLS-1:0] state_0,
    output logic                 grid_rst,
    output logic                 grid_ena,
    output logic [15:0]          generation,
    output logic                 loaded,
    output logic                 frame_err
);

    localparam int NCELLS = ROWS * COLS;
    localparam int NBYTES = NCELLS / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0]    IDX_ZERO    = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]    IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NBYTES - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] PERIOD_ONE  = PERIOD_W'(1);
    localparam logic [NCELLS-1:0]   CELLS_ZERO  = {NCELLS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_APPLY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Registered state
    state_t              state_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic                apply_cnt_r;
    logic [PERIOD_W-1:0] period_cnt_r;
    logic [NCELLS-1:0]   shadow_r;
    logic [NCELLS-1:0]   state_0_r;
    logic                seed_ready_r;
    logic                grid_rst_r;
    logic                grid_ena_r;
    logic [15:0]         generation_r;
    logic                loaded_r;
    logic                frame_err_r;

    // Combinational next-state / control
    state_t              next_state_s;
    logic [IDX_W-1:0]    byte_idx_next_s;
    logic [NCELLS-1:0]   shadow_next_s;
    logic [PERIOD_W-1:0] period_cnt_next_s;
    logic [PERIOD_W-1:0] period_eff_s;
    logic                period_term_s;
    logic                accept_s;
    logic                frame_err_set_s;
    logic                loaded_clr_s;
    logic                fire_s;
    logic                apply_done_s;

    // Writes one seed byte into its slot of the cell vector; bit i of byte b
    // lands on cell 8*b+i.
    function automatic logic [NCELLS-1:0] merge_byte(
        input logic [NCELLS-1:0] vec,
        input logic [IDX_W-1:0]  idx,
        input logic [7:0]        data
    );
        logic [NCELLS-1:0] tmp;
        tmp = vec;
        tmp[8*int'(idx) +: 8] = data;
        return tmp;
    endfunction

    // A byte transfers whenever the upstream offers one while we advertise ready.
    assign accept_s = seed_valid && seed_ready_r;

    // Effective period (0 behaves as 1) and the wrap compare; >= keeps the
    // counter firing even if period is lowered below the current count.
    always_comb begin
        if (period == PERIOD_ZERO) begin
            period_eff_s = PERIOD_ONE;
        end else begin
            period_eff_s = period;
        end
        period_term_s = (period_cnt_r >= (period_eff_s - PERIOD_ONE));
    end

    // Next-state logic: frame assembly, frame checking, apply sequencing and
    // generation pacing.
    always_comb begin
        next_state_s      = state_r;
        byte_idx_next_s   = byte_idx_r;
        shadow_next_s     = shadow_r;
        period_cnt_next_s = PERIOD_ZERO;
        frame_err_set_s   = 1'b0;
        loaded_clr_s      = 1'b0;
        fire_s            = 1'b0;
        apply_done_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOAD, ST_RUN: begin
                if (accept_s) begin
                    // A byte arriving while running starts a reload; any
                    // enable due this cycle is dropped because fire_s stays 0.
                    shadow_next_s = merge_byte(shadow_r, byte_idx_r, seed_data);
                    loaded_clr_s  = (state_r == ST_RUN);
                    if (byte_idx_r == LAST_IDX) begin
                        byte_idx_next_s = IDX_ZERO;
                        if (seed_last) begin
                            next_state_s = ST_APPLY;
                        end else begin
                            next_state_s    = ST_IDLE;
                            frame_err_set_s = 1'b1;
                            loaded_clr_s    = 1'b1;
                        end
                    end else begin
                        if (seed_last) begin
                            byte_idx_next_s = IDX_ZERO;
                            next_state_s    = ST_IDLE;
                            frame_err_set_s = 1'b1;
                            loaded_clr_s    = 1'b1;
                        end else begin
                            byte_idx_next_s = byte_idx_r + IDX_ONE;
                            next_state_s    = ST_LOAD;
                        end
                    end
                end else if (state_r == ST_RUN) begin
                    if (run) begin
                        if (period_term_s) begin
                            fire_s = 1'b1;
                        end else begin
                            period_cnt_next_s = period_cnt_r + PERIOD_ONE;
                        end
                    end else begin
                        fire_s = step;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_APPLY: begin
                if (apply_cnt_r) begin
                    next_state_s = ST_RUN;
                    apply_done_s = 1'b1;
                end else begin
                    next_state_s = ST_APPLY;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame assembly and pacing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_r   <= IDX_ZERO;
            shadow_r     <= CELLS_ZERO;
            apply_cnt_r  <= 1'b0;
            period_cnt_r <= PERIOD_ZERO;
        end else begin
            byte_idx_r   <= byte_idx_next_s;
            shadow_r     <= shadow_next_s;
            apply_cnt_r  <= (state_r == ST_APPLY) ? ~apply_cnt_r : 1'b0;
            period_cnt_r <= period_cnt_next_s;
        end
    end

    // Handshake and grid control outputs, decoded from the upcoming state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_ready_r <= 1'b0;
            grid_rst_r   <= 1'b1;
            grid_ena_r   <= 1'b0;
        end else begin
            seed_ready_r <= (next_state_s != ST_APPLY);
            grid_rst_r   <= (next_state_s == ST_APPLY);
            grid_ena_r   <= fire_s;
        end
    end

    // Seed vector to the grid: replaced in one step on APPLY entry only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_0_r <= CELLS_ZERO;
        end else if ((next_state_s == ST_APPLY) && (state_r != ST_APPLY)) begin
            state_0_r <= shadow_next_s;
        end else begin
            state_0_r <= state_0_r;
        end
    end

    // Generation count, loaded flag and sticky frame error.
    always_ff @(posedge clk) begin
        if (rst) begin
            generation_r <= 16'h0000;
            loaded_r     <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (apply_done_s) begin
                generation_r <= 16'h0000;
            end else if (fire_s) begin
                generation_r <= generation_r + 16'h0001;
            end else begin
                generation_r <= generation_r;
            end
            if (apply_done_s) begin
                loaded_r <= 1'b1;
            end else if (loaded_clr_s) begin
                loaded_r <= 1'b0;
            end else begin
                loaded_r <= loaded_r;
            end
            if (frame_err_set_s) begin
                frame_err_r <= 1'b1;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign seed_ready = seed_ready_r;
    assign state_0    = state_0_r;
    assign grid_rst   = grid_rst_r;
    assign grid_ena   = grid_ena_r;
    assign generation = generation_r;
    assign loaded     = loaded_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_conway_seed_loader.sv
// Self-checking bench for conway_seed_loader: expected seed vectors and
// generation numbers are queued as stimulus is driven and compared when the
// grid_rst / grid_ena outputs show up.
module tb_conway_seed_loader;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int PERIOD_W = 24;
    localparam int NCELLS   = ROWS * COLS;
    localparam int NBYTES   = NCELLS / 8;

    logic                clk        = 1'b0;
    logic                rst        = 1'b1;
    logic                seed_valid = 1'b0;
    logic [7:0]          seed_data  = 8'h00;
    logic                seed_last  = 1'b0;
    logic                run        = 1'b0;
    logic                step       = 1'b0;
    logic [PERIOD_W-1:0] period     = 24'd0;
    logic                seed_ready;
    logic [NCELLS-1:0]   state_0;
    logic                grid_rst;
    logic                grid_ena;
    logic [15:0]         generation;
    logic                loaded;
    logic                frame_err;

    int checks = 0;
    int errors = 0;
    int send_timeouts = 0;

    logic [7:0]        frame_buf [NBYTES];
    logic [NCELLS-1:0] exp_state_q [$];
    logic [15:0]       exp_gen_q [$];
    logic [15:0]       exp_gen = 16'd0;

    conway_seed_loader #(.ROWS(ROWS), .COLS(COLS), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed_data(seed_data), .seed_last(seed_last), .run(run), .step(step),
        .period(period), .state_0(state_0), .grid_rst(grid_rst), .grid_ena(grid_ena),
        .generation(generation), .loaded(loaded), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // grid_rst and grid_ena must never be high together.
    always @(negedge clk) begin
        if (!rst && grid_rst === 1'b1 && grid_ena === 1'b1) begin
            errors++;
            $display("FAIL rst_ena_overlap grid_rst=%b grid_ena=%b required not both 1", grid_rst, grid_ena);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        seed_valid = 1'b1;
        seed_data  = d;
        seed_last  = l;
        while (seed_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (seed_ready !== 1'b1) send_timeouts++;
        tick();
        seed_valid = 1'b0;
        seed_last  = 1'b0;
    endtask

    // Send frame_buf[0..n-1]; seed_last on byte last_at (-1 for none).
    task automatic send_frame(input int n, input int last_at);
        for (int b = 0; b < n; b++) send_byte(frame_buf[b], (b == last_at));
    endtask

    task automatic wait_loaded(output bit ok);
        int n;
        n = 0;
        while (loaded !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        ok = (loaded === 1'b1);
    endtask

    function automatic logic [NCELLS-1:0] frame_vec();
        logic [NCELLS-1:0] v;
        v = {NCELLS{1'b0}};
        for (int b = 0; b < NBYTES; b++) v[8*b +: 8] = frame_buf[b];
        return v;
    endfunction

    task automatic random_frame(input logic [7:0] first);
        for (int b = 0; b < NBYTES; b++) frame_buf[b] = 8'($urandom);
        frame_buf[0] = first;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (grid_rst !== 1'b1) begin errors++; $display("FAIL reset_grid_rst actual=%b required=1", grid_rst); end
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL reset_seed_ready actual=%b required=0", seed_ready); end
        checks++; if (state_0 !== {NCELLS{1'b0}}) begin errors++; $display("FAIL reset_state_0 actual=%h required=0", state_0); end
        checks++; if (grid_ena !== 1'b0 || loaded !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_flags ena=%b loaded=%b frame_err=%b required 0 0 0", grid_ena, loaded, frame_err); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL reset_generation actual=%0d required=0", generation); end
        rst = 1'b0;
        tick();
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL release_seed_ready actual=%b required=1", seed_ready); end
        checks++; if (grid_rst !== 1'b0 || grid_ena !== 1'b0 || loaded !== 1'b0) begin errors++; $display("FAIL release_flags rst=%b ena=%b loaded=%b required 0 0 0", grid_rst, grid_ena, loaded); end
    endtask

    task automatic test_load();
        logic [NCELLS-1:0] prev, e;
        int changes, rst_cycles, ena_seen;
        for (int b = 0; b < NBYTES; b++) frame_buf[b] = 8'h00;
        frame_buf[1] = 8'h1C;
        exp_state_q.push_back(frame_vec());
        prev = state_0; changes = 0; rst_cycles = 0; ena_seen = 0;
        send_frame(NBYTES, NBYTES - 1);
        for (int i = 0; i < 6; i++) begin
            if (grid_rst === 1'b1) rst_cycles++;
            if (grid_ena === 1'b1) ena_seen++;
            if (state_0 !== prev) begin changes++; prev = state_0; end
            tick();
        end
        e = exp_state_q.pop_front();
        checks++; if (state_0 !== e) begin errors++; $display("FAIL load_state_0 actual=%h required=%h", state_0, e); end
        checks++; if (changes != 1) begin errors++; $display("FAIL load_state_0_updates actual=%0d required=1", changes); end
        checks++; if (rst_cycles != 2) begin errors++; $display("FAIL load_grid_rst_cycles actual=%0d required=2", rst_cycles); end
        checks++; if (ena_seen != 0) begin errors++; $display("FAIL load_ena actual=%0d required=0", ena_seen); end
        checks++; if (loaded !== 1'b1 || generation !== 16'd0) begin errors++; $display("FAIL load_done loaded=%b gen=%0d required 1 0", loaded, generation); end
        checks++; if (send_timeouts != 0) begin errors++; $display("FAIL load_handshake timeouts=%0d required=0", send_timeouts); end
        exp_gen = 16'd0;
    endtask

    task automatic test_free_run();
        int last_c, pulses;
        logic [15:0] e;
        last_c = -1; pulses = 0;
        for (int k = 1; k <= 10; k++) exp_gen_q.push_back(exp_gen + 16'(k));
        period = 24'd4; run = 1'b1;
        for (int c = 0; c < 80 && pulses < 10; c++) begin
            tick();
            if (grid_ena === 1'b1) begin
                e = exp_gen_q.pop_front();
                checks++; if (generation !== e) begin errors++; $display("FAIL free_run_gen actual=%0d required=%0d", generation, e); end
                if (last_c >= 0) begin
                    checks++; if (c - last_c != 4) begin errors++; $display("FAIL free_run_interval actual=%0d required=4", c - last_c); end
                end
                last_c = c;
                pulses++;
            end
        end
        run = 1'b0;
        exp_gen_q.delete();
        exp_gen = exp_gen + 16'd10;
        checks++; if (pulses != 10) begin errors++; $display("FAIL free_run_pulses actual=%0d required=10", pulses); end
        checks++; if (generation !== exp_gen) begin errors++; $display("FAIL free_run_total actual=%0d required=%0d", generation, exp_gen); end
        tick();
        checks++; if (grid_ena !== 1'b0) begin errors++; $display("FAIL free_run_stop actual=%b required=0", grid_ena); end
        period = 24'd0; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_gen = exp_gen + 16'd1;
            checks++; if (grid_ena !== 1'b1 || generation !== exp_gen) begin errors++; $display("FAIL period0_ena ena=%b gen=%0d required 1 %0d", grid_ena, generation, exp_gen); end
        end
        run = 1'b0;
        tick();
        checks++; if (grid_ena !== 1'b0 || generation !== exp_gen) begin errors++; $display("FAIL period0_stop ena=%b gen=%0d required 0 %0d", grid_ena, generation, exp_gen); end
    endtask

    task automatic test_single_step();
        logic [15:0] e;
        int cnt;
        for (int k = 0; k < 3; k++) begin
            exp_gen = exp_gen + 16'd1;
            exp_gen_q.push_back(exp_gen);
            step = 1'b1;
            tick();
            step = 1'b0;
            e = exp_gen_q.pop_front();
            checks++; if (grid_ena !== 1'b1 || generation !== e) begin errors++; $display("FAIL step_pulse ena=%b gen=%0d required 1 %0d", grid_ena, generation, e); end
            tick();
            checks++; if (grid_ena !== 1'b0) begin errors++; $display("FAIL step_width actual=%b required=0", grid_ena); end
            repeat (3) tick();
        end
        cnt = 0;
        step = 1'b1;
        repeat (3) begin tick(); if (grid_ena === 1'b1) cnt++; end
        step = 1'b0;
        tick();
        if (grid_ena === 1'b1) cnt++;
        exp_gen = exp_gen + 16'd3;
        checks++; if (cnt != 3) begin errors++; $display("FAIL step_hold_pulses actual=%0d required=3", cnt); end
        checks++; if (generation !== exp_gen) begin errors++; $display("FAIL step_hold_gen actual=%0d required=%0d", generation, exp_gen); end
    endtask

    task automatic test_malformed();
        logic [NCELLS-1:0] prev, e;
        bit ok;
        prev = state_0;
        for (int b = 0; b < NBYTES; b++) frame_buf[b] = 8'hFF;
        send_frame(4, 3);
        checks++; if (frame_err !== 1'b1 || loaded !== 1'b0) begin errors++; $display("FAIL short_frame_flags err=%b loaded=%b required 1 0", frame_err, loaded); end
        checks++; if (state_0 !== prev) begin errors++; $display("FAIL short_frame_state_0 actual=%h required=%h", state_0, prev); end
        checks++; if (seed_ready !== 1'b1 || grid_rst !== 1'b0) begin errors++; $display("FAIL short_frame_idle ready=%b rst=%b required 1 0", seed_ready, grid_rst); end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (grid_ena !== 1'b0) begin errors++; $display("FAIL idle_step_ignored actual=%b required=0", grid_ena); end
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_cleared actual=%b required=0", frame_err); end
        random_frame(8'h3C);
        send_frame(NBYTES, -1);
        checks++; if (frame_err !== 1'b1 || loaded !== 1'b0) begin errors++; $display("FAIL no_last_flags err=%b loaded=%b required 1 0", frame_err, loaded); end
        checks++; if (state_0 !== {NCELLS{1'b0}}) begin errors++; $display("FAIL no_last_state_0 actual=%h required=0", state_0); end
        random_frame(8'h96);
        exp_state_q.push_back(frame_vec());
        send_frame(NBYTES, NBYTES - 1);
        wait_loaded(ok);
        e = exp_state_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL recover_loaded actual=%b required=1", loaded); end
        checks++; if (state_0 !== e) begin errors++; $display("FAIL recover_state_0 actual=%h required=%h", state_0, e); end
        checks++; if (frame_err !== 1'b1 || generation !== 16'd0) begin errors++; $display("FAIL recover_flags err=%b gen=%0d required 1 0", frame_err, generation); end
    endtask

    task automatic test_reload_running();
        logic [NCELLS-1:0] prev, e;
        bit ok;
        int n, ena_cnt;
        period = 24'd2; run = 1'b1;
        n = 0;
        while (grid_ena !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (grid_ena !== 1'b1 || generation !== 16'd1) begin errors++; $display("FAIL reload_first_pulse ena=%b gen=%0d required 1 1", grid_ena, generation); end
        tick();
        prev = state_0;
        random_frame(8'h5A);
        exp_state_q.push_back(frame_vec());
        seed_valid = 1'b1; seed_data = frame_buf[0]; seed_last = 1'b0;
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL reload_ready actual=%b required=1", seed_ready); end
        tick();
        seed_valid = 1'b0;
        checks++; if (grid_ena !== 1'b0 || loaded !== 1'b0) begin errors++; $display("FAIL reload_suppress ena=%b loaded=%b required 0 0", grid_ena, loaded); end
        checks++; if (generation !== 16'd1 || state_0 !== prev) begin errors++; $display("FAIL reload_frozen gen=%0d state_0=%h required 1 %h", generation, state_0, prev); end
        ena_cnt = 0;
        repeat (4) begin tick(); if (grid_ena === 1'b1) ena_cnt++; end
        checks++; if (ena_cnt != 0 || generation !== 16'd1) begin errors++; $display("FAIL reload_hold ena_pulses=%0d gen=%0d required 0 1", ena_cnt, generation); end
        for (int b = 1; b < NBYTES; b++) send_byte(frame_buf[b], (b == NBYTES - 1));
        wait_loaded(ok);
        e = exp_state_q.pop_front();
        checks++; if (!ok || generation !== 16'd0) begin errors++; $display("FAIL reload_apply loaded=%b gen=%0d required 1 0", loaded, generation); end
        checks++; if (state_0 !== e) begin errors++; $display("FAIL reload_state_0 actual=%h required=%h", state_0, e); end
        n = 0;
        while (grid_ena !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (grid_ena !== 1'b1 || generation !== 16'd1) begin errors++; $display("FAIL reload_resume ena=%b gen=%0d required 1 1", grid_ena, generation); end
        tick();
        n = 1;
        while (grid_ena !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (n != 2 || generation !== 16'd2) begin errors++; $display("FAIL reload_interval cycles=%0d gen=%0d required 2 2", n, generation); end
        run = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        tick();
        random_frame(8'h81);
        send_frame(NBYTES, NBYTES - 1);
        wait_loaded(ok);
        checks++; if (!ok || generation !== 16'd0) begin errors++; $display("FAIL wrap_load loaded=%b gen=%0d required 1 0", loaded, generation); end
        period = 24'd1; run = 1'b1;
        repeat (65535) tick();
        checks++; if (generation !== 16'hFFFF || grid_ena !== 1'b1) begin errors++; $display("FAIL wrap_top gen=%h ena=%b required ffff 1", generation, grid_ena); end
        tick();
        checks++; if (generation !== 16'h0000) begin errors++; $display("FAIL wrap_zero actual=%h required=0000", generation); end
        run = 1'b0;
        tick();
        checks++; if (grid_ena !== 1'b0) begin errors++; $display("FAIL wrap_stop actual=%b required=0", grid_ena); end
    endtask

    task automatic test_reset_mid();
        logic [NCELLS-1:0] e;
        bit ok;
        random_frame(8'hC3);
        for (int b = 0; b < 3; b++) send_byte(frame_buf[b], 1'b0);
        run = 1'b1;
        rst = 1'b1;
        tick();
        checks++; if (state_0 !== {NCELLS{1'b0}} || grid_rst !== 1'b1) begin errors++; $display("FAIL midreset_grid state_0=%h rst=%b required 0 1", state_0, grid_rst); end
        checks++; if (grid_ena !== 1'b0 || loaded !== 1'b0 || frame_err !== 1'b0 || seed_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags ena=%b loaded=%b err=%b ready=%b required 0 0 0 0", grid_ena, loaded, frame_err, seed_ready); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL midreset_gen actual=%0d required=0", generation); end
        rst = 1'b0; run = 1'b0;
        tick();
        random_frame(8'h6E);
        exp_state_q.push_back(frame_vec());
        send_frame(NBYTES, NBYTES - 1);
        wait_loaded(ok);
        e = exp_state_q.pop_front();
        checks++; if (!ok || state_0 !== e) begin errors++; $display("FAIL midreset_reload loaded=%b state_0=%h required 1 %h", loaded, state_0, e); end
        checks++; if (frame_err !== 1'b0 || send_timeouts != 0) begin errors++; $display("FAIL midreset_clean err=%b timeouts=%0d required 0 0", frame_err, send_timeouts); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_free_run();
        test_single_step();
        test_malformed();
        test_reload_running();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
